// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
//   Nop            : canonical RV32I NOP (addi x0, x0, 0), presented to decode when empty
//   DefaultResetPc : default boot address
//   fetch_state_e  : fetch FSM states (StHalt only reachable with FETCH_MISALIGN_TRAP_EN)
package instr_fetch_pkg;

  localparam logic [31:0] Nop            = 32'h0000_0013;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StFetch = 2'd1,
    StHalt  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch FIFO for the fetch stage: synchronous, power-of-two depth, with flush.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, wdata  : write wdata at tail (caller guarantees not full, or full with pop)
//   pop          : advance head (caller guarantees not empty)
//   flush        : discard all entries; overrides push and pop
//   rdata        : head entry
//   full, empty  : occupancy flags
module instr_fetch_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, tail_q;
  logic [PtrW:0]    count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PtrW'(1);
      if (pop)  head_q <= head_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= wdata;
  end

  assign rdata = mem_q[head_q];
  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory strobe/address,
// queues {pc, instr} in a prefetch FIFO and hands the head to decode over valid/ready.
// A redirect flushes the queue and reloads the PC.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect halts fetch and
// raises a sticky o_misalign; without it the target is force-aligned).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   o_imem_addr, o_imem_stb    : fetch request (address is the pc register)
//   i_imem_ack, i_imem_data    : memory response, data valid with ack
//   o_valid, i_ready           : FIFO head handshake to decode
//   o_instr, o_pc              : head entry (NOP / 0 when empty)
//   i_redirect, i_redirect_pc  : single-cycle redirect and target
//   o_misalign                 : misaligned-redirect trap flag (macro builds only)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DefaultResetPc,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_stb,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        o_misalign,
`endif
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_tgt;
  logic         fifo_full, fifo_empty;
  logic [63:0]  fifo_head;
  logic         pop, push;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic redirect_bad;

  assign redirect_bad = (i_redirect_pc[1:0] != 2'b00);
  // The misaligned target is kept in pc so the trap handler can inspect it.
  assign redirect_tgt = i_redirect_pc;
  assign o_misalign   = misalign_q;
`else
  assign redirect_tgt = i_redirect_pc & 32'hFFFF_FFFC;
`endif

  assign o_valid    = !fifo_empty;
  assign pop        = o_valid && i_ready;
  // A full FIFO may still accept a word when decode drains the head this cycle.
  assign o_imem_stb = (state_q == StFetch) && !i_redirect && (!fifo_full || pop);
  assign push       = o_imem_stb && i_imem_ack && !i_redirect;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif

    if (i_redirect) begin
      pc_d = redirect_tgt;
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end

    case (state_q)
      StBoot:  state_d = StFetch;
      StFetch: state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StBoot;
    endcase

`ifdef FETCH_MISALIGN_TRAP_EN
    if (i_redirect) begin
      misalign_d = redirect_bad;
      state_d    = redirect_bad ? StHalt : StFetch;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`endif

  instr_fetch_fifo #(
    .Width (64),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (i_redirect),
    .wdata ({pc_q, i_imem_data}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_imem_addr = pc_q;
  assign o_instr     = fifo_empty ? Nop : fifo_head[31:0];
  assign o_pc        = fifo_empty ? 32'h0 : fifo_head[63:32];

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int unsigned Depth   = 2;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] NopWord = 32'h0000_0013;
  localparam int          NCycles = 1500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_stb;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of {pc, instr}, current fetch pc, boot/halt flags.
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_booted;
  bit          m_halt;
  bit          m_mis;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC   (ResetPc),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_imem_addr   (imem_addr),
    .o_imem_stb    (imem_stb),
    .i_imem_ack    (imem_ack),
    .i_imem_data   (imem_data),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_instr       (instr),
    .o_pc          (pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .o_misalign    (misalign),
`endif
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_stb();
    int n = m_q.size();
    return m_booted && !m_halt && !redirect && (n < Depth || (n > 0 && ready));
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc     = ResetPc;
    m_booted = 1'b0;
    m_halt   = 1'b0;
    m_mis    = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at that edge.
  task automatic model_clock();
    bit st = model_stb();
    bit pp = (m_q.size() > 0) && ready;
    if (redirect) begin
      m_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc   = redirect_pc;
      m_halt = (redirect_pc % 4) != 0;
      m_mis  = m_halt;
`else
      m_pc = redirect_pc - (redirect_pc % 4);
`endif
    end else begin
      if (pp) void'(m_q.pop_front());
      if (st && imem_ack) begin
        m_q.push_back({m_pc, imem_data});
        m_pc = m_pc + 32'd4;
      end
    end
    m_booted = 1'b1;
  endtask

  task automatic check_outputs();
    bit          ev = m_q.size() > 0;
    logic [63:0] hd = ev ? m_q[0] : {32'h0, NopWord};
    check_eq("imem_addr", 64'(imem_addr), 64'(m_pc));
    check_eq("imem_stb", 64'(imem_stb), 64'(model_stb()));
    check_eq("valid", 64'(valid), 64'(ev));
    check_eq("instr", 64'(instr), 64'(hd[31:0]));
    check_eq("pc", 64'(pc), 64'(hd[63:32]));
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("misalign", 64'(misalign), 64'(m_mis));
`endif
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_addr", 64'(imem_addr), 64'(ResetPc));
    check_eq("rst_stb", 64'(imem_stb), 64'(0));
    check_eq("rst_valid", 64'(valid), 64'(0));
    check_eq("rst_instr", 64'(instr), 64'(NopWord));
    check_eq("rst_pc", 64'(pc), 64'(0));
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("rst_misalign", 64'(misalign), 64'(0));
`endif
  endtask

  task automatic drive_random(input int cyc);
    int sel;
    // Periodic decode stall so the FIFO fills and the full-with-pop path is exercised.
    ready     = ((cyc % 40) < 8) ? 1'b0 : ($urandom_range(3) != 0);
    imem_ack  = ($urandom_range(3) != 0);
    imem_data = $urandom;
    redirect  = ($urandom_range(19) == 0);
    sel       = $urandom_range(4);
    case (sel)
      0:       redirect_pc = 32'h0000_0200;
      1:       redirect_pc = 32'hFFFF_FFF8;          // walks across the 2^32 wrap
      2:       redirect_pc = 32'h0000_0100;
      3:       redirect_pc = $urandom & 32'hFFFF_FFFC;
      default: redirect_pc = $urandom;               // possibly misaligned
    endcase
  endtask

  task automatic step(input int cyc);
    @(posedge clk);
    model_clock();
    #1;
    drive_random(cyc);
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset between clock edges; outputs must respond immediately.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    redirect = 1'b0;
    imem_ack = 1'b0;
    ready    = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    #2;
    rst_n = 1'b1;

    // Directed start: stream with ready=1 and ack every strobe.
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      model_clock();
      #1;
      ready     = 1'b1;
      imem_ack  = 1'b1;
      imem_data = 32'hA000_0000 + 32'(c);
      redirect  = 1'b0;
      @(negedge clk);
      check_outputs();
    end

    // Directed wrap: redirect to the last word, then ack it.
    @(posedge clk);
    model_clock();
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    check_outputs();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      model_clock();
      #1;
      redirect  = 1'b0;
      imem_ack  = 1'b1;
      ready     = 1'b1;
      imem_data = $urandom;
      @(negedge clk);
      check_outputs();
    end

    for (int c = 0; c < NCycles; c++) begin
      step(c);
      if (c == NCycles / 2) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
